// File: rtl/cls_fault_if.sv
// Handshake bundle between the lockstep compare unit, the fault handler and the core reset fabric.
interface cls_fault_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 enable_i;
  logic [2:0]           mismatch_i;
  logic                 clear_i;
  logic                 core_rst_no;
  logic                 fault_o;
  logic [1:0]           faulty_core_o;
  logic [CNT_WIDTH-1:0] fault_cnt_o;
  logic                 busy_o;
  logic                 failed_o;

  modport master (
    output enable_i, mismatch_i, clear_i,
    input  core_rst_no, fault_o, faulty_core_o, fault_cnt_o, busy_o, failed_o
  );

  modport slave (
    input  enable_i, mismatch_i, clear_i,
    output core_rst_no, fault_o, faulty_core_o, fault_cnt_o, busy_o, failed_o
  );
endinterface

// File: rtl/cls_fault_handler.sv
// Lockstep recovery controller: filters pairwise mismatches, diagnoses the odd core out,
// pulses a recovery reset, watches a recovery window and escalates to a sticky failure.
module cls_fault_handler #(
  parameter int FILTER_CYCLES  = 2,
  parameter int RST_CYCLES     = 16,
  parameter int RECOVER_CYCLES = 64,
  parameter int MAX_RETRIES    = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  cls_fault_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RESET, RECOVER, FAILED} state_t;

  localparam int TMAX = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
  localparam int FW   = $clog2(FILTER_CYCLES) + 1;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int RW   = $clog2(MAX_RETRIES) + 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] REC_LAST  = TW'(RECOVER_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  state_t               state_q, state_d;
  logic [FW-1:0]        filt_q, filt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_base;
  logic [1:0]           diag, core_q;
  logic                 fault_q, core_rst_n_q, busy_q, failed_q;
  logic                 qualify, confirm;

  assign qualify = bus.enable_i && (bus.mismatch_i != 3'b000) &&
                   ((state_q == IDLE) || (state_q == RECOVER));
  assign confirm = qualify && (filt_q == FILT_LAST);

  // The core that disagrees with both others is the one outside the clean pair.
  always_comb begin
    diag = 2'd0;
    case (bus.mismatch_i)
      3'b011:  diag = 2'd1;
      3'b101:  diag = 2'd2;
      3'b110:  diag = 2'd3;
      default: diag = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = timer_q + TW'(1);
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (confirm) begin
          state_d = RESET;
          retry_d = RW'(1);
        end
      end
      RESET: begin
        if (timer_q == RST_LAST) state_d = RECOVER;
      end
      RECOVER: begin
        if (confirm) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAILED;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = RESET;
          end
        end else if (timer_q == REC_LAST) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      FAILED: begin
        timer_d = '0;
        if (bus.clear_i) begin
          state_d = IDLE;
          retry_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Both the window timer and the filter restart whenever the state changes.
    if (state_d != state_q) timer_d = '0;
    filt_d = (qualify && (state_d == state_q)) ? filt_q + FW'(1) : '0;

    cnt_base = bus.clear_i ? '0 : cnt_q;
    cnt_d    = (confirm && (cnt_base != '1)) ? cnt_base + CNT_WIDTH'(1) : cnt_base;
  end

  // Outputs are derived from the next state so they line up with the state they describe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      filt_q       <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      cnt_q        <= '0;
      core_q       <= 2'd0;
      fault_q      <= 1'b0;
      core_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      filt_q       <= filt_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      fault_q      <= confirm;
      if (confirm) core_q <= diag;
      core_rst_n_q <= !((state_d == RESET) || (state_d == FAILED));
      busy_q       <= (state_d == RESET) || (state_d == RECOVER);
      failed_q     <= (state_d == FAILED);
    end
  end

  assign bus.core_rst_no   = core_rst_n_q;
  assign bus.fault_o       = fault_q;
  assign bus.faulty_core_o = core_q;
  assign bus.fault_cnt_o   = cnt_q;
  assign bus.busy_o        = busy_q;
  assign bus.failed_o      = failed_q;

endmodule

// File: doc/cls_fault_handler.md
# cls_fault_handler

Recovery controller downstream of the core-lockstep compare unit in the triple-core minion cluster. It consumes the three pairwise mismatch flags (master/slave1, master/slave2, slave1/slave2) and filters transient disagreements. On a confirmed fault it diagnoses the faulty core, pulses a recovery reset to all three cores, and monitors a recovery window. After repeated failed retries it escalates to a sticky failed state.

## Interface
- FILTER_CYCLES, 2, consecutive cycles of non-zero mismatch required to confirm a fault (>=1)
- RST_CYCLES, 16, length of recovery reset pulse in cycles (>=1)
- RECOVER_CYCLES, 64, post-reset observation window in cycles (>=1)
- MAX_RETRIES, 3, recovery resets attempted before FAILED (>=1)
- CNT_WIDTH, 8, width of fault counter

- clk_i  in  1  clock; one clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  1 = mismatches are evaluated; 0 = mismatches ignored
- mismatch_i  in  3  [0] master≠sl1, [1] master≠sl2, [2] sl1≠sl2
- clear_i  in  1  clears fault_cnt_o and failed_o; exits FAILED
- core_rst_no  out  1  registered active-low reset to all three cores; ANDed with rst_ni externally
- fault_o  out  1  one-cycle pulse per confirmed fault
- faulty_core_o  out  2  diagnosis latched at confirmation: 0 undiagnosable, 1 master, 2 slave1, 3 slave2
- fault_cnt_o  out  CNT_WIDTH  confirmed faults, saturating at all-ones
- busy_o  out  1  1 in RESET or RECOVER
- failed_o  out  1  sticky, 1 in FAILED

## Operation
- States: IDLE, RESET, RECOVER, FAILED. Reset state is IDLE.
- Filter counter `filt`:
  - Increments when enable_i=1 and mismatch_i≠0 in IDLE or RECOVER.
  - Clears to 0 on any cycle with mismatch_i=0 or enable_i=0, and on every state change.
  - A fault is confirmed on the cycle `filt` reaches FILTER_CYCLES-1 while the condition still holds. With FILTER_CYCLES=1, confirmation is immediate.
- Diagnosis from mismatch_i at confirmation:
  - 3'b011 → 1 (master)
  - 3'b101 → 2 (slave1)
  - 3'b110 → 3 (slave2)
  - Any other pattern → 0
- On confirmation:
  - fault_o pulses and faulty_core_o is latched.
  - fault_cnt_o increments (saturating).
  - From IDLE: retry counter is set to 1, go to RESET.
  - From RECOVER: if retry = MAX_RETRIES go to FAILED; else retry++ and go to RESET.
- RESET: core_rst_no=0 for exactly RST_CYCLES cycles, mismatch_i ignored, then go to RECOVER.
- RECOVER: core_rst_no=1, window counter runs. If RECOVER_CYCLES cycles pass with no confirmation, go to IDLE and clear retry.
- FAILED: core_rst_no=0 held, failed_o=1, mismatch_i ignored. clear_i=1 → IDLE, retry=0.
- clear_i outside FAILED:
  - Clears fault_cnt_o; FSM is unaffected.
  - If a confirmation occurs in the same cycle, fault_cnt_o becomes 1 (clear applied first, then increment).
- enable_i=0 during RESET/RECOVER: the sequence continues; no new confirmations occur.

## Timing
- All outputs are registered.
- Reset values: core_rst_no=1, fault_o=0, faulty_core_o=0, fault_cnt_o=0, busy_o=0, failed_o=0.
- Confirmation latency, with mismatch held from cycle t:
  - State changes at the edge ending cycle t+FILTER_CYCLES-1.
  - fault_o=1, core_rst_no=0 and busy_o=1 are all visible in cycle t+FILTER_CYCLES.
- core_rst_no is low for cycles t+F … t+F+RST_CYCLES-1 and returns to 1 in cycle t+F+RST_CYCLES.
- RECOVER lasts RECOVER_CYCLES cycles; busy_o drops in the first IDLE cycle.
- Entry to FAILED: failed_o=1 and core_rst_no=0 in the same cycle fault_o pulses.
- rst_ni asserted mid-sequence immediately forces all reset values, including core_rst_no=1.
- Mismatch held continuously across the RESET→RECOVER transition: `filt` restarts at RECOVER entry, so confirmation takes FILTER_CYCLES cycles into RECOVER.

## Test plan
- **Transient filtered:** mismatch_i=3'b011 for 1 cycle, enable_i=1, defaults → no fault_o; core_rst_no stays 1; fault_cnt_o=0.
- **Single fault recovered:** mismatch_i=3'b101 for 2 cycles, then 0 → fault_o pulse 1 cycle; faulty_core_o=2; core_rst_no low exactly 16 cycles; busy_o high 16+64 cycles; then IDLE with fault_cnt_o=1.
- **Escalation:** mismatch_i=3'b110 held continuously → three confirmations (2 cycles into IDLE, then 2 cycles into each RECOVER); fourth confirmation enters FAILED; failed_o=1; core_rst_no=0 held; fault_cnt_o=4.
- **Clear from FAILED:** from the escalation end state, clear_i=1 for 1 cycle → next cycle state IDLE, failed_o=0, fault_cnt_o=0, core_rst_no=1.
- **Disable and undiagnosable:** enable_i=0 with mismatch_i=3'b111 for 10 cycles → no response. Then enable_i=1 for 2 cycles → faulty_core_o=0, fault_o pulse.
- **Async reset mid-RESET:** rst_ni low in the 5th cycle of the reset pulse → core_rst_no=1, busy_o=0, fault_cnt_o=0 without waiting for a clock edge.
